restoring_div: RTL and testbench
================================

RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured on the edge that accepts start.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured on the edge that accepts start.
REQ-007 quotient  output  WIDTH  registered quotient; valid from done, held until the next result.
REQ-008 remainder  output  WIDTH  registered remainder; valid from done, held until the next result.
REQ-009 busy  output  1  high from the accepting edge until DONE is entered.
REQ-010 done  output  1  one-cycle pulse in the DONE state.
REQ-011 div_zero  output  1  high with done when the divisor was 0; held with the results.

Function
REQ-012 States: IDLE, ITER, DONE; registered state; encoding comes from the package.
REQ-013 IDLE with start=1:
- A (WIDTH+1 bits) <= 0, Q <= dividend, M <= divisor, count <= WIDTH, busy <= 1.
- Next state is ITER; if divisor==0 the next state is DONE.
REQ-014 IDLE with start=0: all registers hold.
REQ-015 One ITER cycle performs one iteration:
- {A,Q} shifted left by 1 (zero into Q[0]); trial = shifted A - {0,M}, computed WIDTH+1 bits wide.
- trial MSB==0: A <= trial, Q[0] <= 1.
- trial MSB==1: A <= shifted A, Q[0] <= 0.
- count <= count-1.
REQ-016 ITER exits to DONE on the edge where count goes from 1 to 0, after exactly WIDTH iterations.
REQ-017 On entry to DONE: quotient <= Q, remainder <= A[WIDTH-1:0], div_zero <= 0, busy <= 0.
REQ-018 Divide-by-zero entry to DONE:
- quotient <= all ones, remainder <= dividend, div_zero <= 1.
- No iterations are run.
REQ-019 DONE lasts exactly one cycle (done=1), then returns to IDLE.
REQ-020 Latency:
- Nonzero divisor: done is high in the cycle after the (WIDTH+1)th rising edge counted from the accepting edge (edge 1 = accepting edge).
- Zero divisor: done is high in the cycle after the accepting edge.
REQ-021 start while in ITER or DONE is ignored; operands are not re-captured and no request is queued.
REQ-022 quotient, remainder and div_zero change only on entry to DONE or on reset.
REQ-023 Operand changes after acceptance do not affect the result.

Reset
REQ-024 rst=1 forces asynchronously, at any time including mid-ITER:
- state=IDLE;
- A, Q, M, count = 0;
- quotient=0, remainder=0, busy=0, done=0, div_zero=0.
REQ-025 After rst deasserts, the first rising edge with start=1 in IDLE starts a fresh operation; no partial result survives reset.

Structure
REQ-026 Shared package div_pkg holds:
- the state typedef (IDLE, ITER, DONE);
- default WIDTH;
- count width = clog2(WIDTH+1).
REQ-027 One sub-module div_shift_reg holds the A:Q register pair:
- Operations: load, shift-left-and-set-Q0, hold.
- It has the same clk/rst and reset behaviour as this block.
REQ-028 Control FSM, counter, subtractor and result registers reside in restoring_div.

Verification
REQ-029 dividend=13, divisor=3, start one cycle:
- busy for 4 iterations; done pulse; quotient=4, remainder=1, div_zero=0.
REQ-030 Boundary values, each run on its own:
- 15/1 -> quotient=15, remainder=0.
- 5/7 -> quotient=0, remainder=5.
- 15/15 -> quotient=1, remainder=0.
REQ-031 9/0 -> done in the cycle after the accepting edge; quotient=15, remainder=9, div_zero=1.
REQ-032 Operations while busy:
- 13/3 started; start=1 with 6/2 and changed operands driven through ITER and DONE.
- Required: a single done pulse, result 4 r 1.
- Next start in IDLE for 6/2 gives quotient=3, remainder=0.
REQ-033 rst pulsed during the 2nd ITER cycle of 13/3:
- Required: all outputs 0 immediately, state IDLE, no done pulse.
- A following 14/4 gives quotient=3, remainder=2.
REQ-034 Exhaustive sweep of all 256 WIDTH=4 operand pairs against a reference model:
- divisor!=0: quotient = a/b, remainder = a%b.
- divisor==0: quotient=15, remainder=a, div_zero=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding,
// default operand width and the iteration-counter width helper.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_shift_reg.sv
// Partial-remainder / quotient register pair (A:Q) of the restoring divider.
// Supports load (A cleared, Q from dividend), shift-left-with-new-Q0, and hold.
module div_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_q,
    input  logic [WIDTH:0]   a_in,
    input  logic             q0,
    output logic [WIDTH:0]   a,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            q <= '0;
        end else if (load) begin
            a <= '0;
            q <= load_q;
        end else if (shift) begin
            a <= a_in;
            q <= (q << 1) | WIDTH'(q0);
        end
    end

endmodule

// File: rtl/restoring_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per ITER cycle,
// results registered on entry to DONE, divide-by-zero short-circuits to DONE.
module restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   a_new;
    logic [WIDTH-1:0] q_new;
    logic             q0;
    logic             unused_a_msb;

    // A never exceeds the divisor, so its top bit only matters as the
    // borrow position of the trial subtraction.
    assign unused_a_msb = a[WIDTH];

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == ITER) && (count == CW'(1));

    // One restoring step: shift A:Q, try subtracting M, keep the result only
    // if it did not borrow.
    always_comb begin
        a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
        trial   = a_shift - {1'b0, m};
        q0      = ~trial[WIDTH];
        a_new   = q0 ? trial : a_shift;
        q_new   = (q << 1) | WIDTH'(q0);
    end

    div_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (state == ITER),
        .load_q (dividend),
        .a_in   (a_new),
        .q0     (q0),
        .a      (a),
        .q      (q)
    );

    // NOTE: the default assignment first means every path assigns
    // state_next, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : ITER;
            ITER: if (count == CW'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            m         <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                m     <= divisor;
                count <= CW'(WIDTH);
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend;
                    div_zero  <= 1'b1;
                end
            end else if (state == ITER) begin
                count <= count - CW'(1);
            end
            // Final iteration's outcome goes straight into the result registers.
            if (last_iter) begin
                quotient  <= q_new;
                remainder <= a_new[WIDTH-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

    assign busy = (state == ITER);
    assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_div.sv
// Self-checking bench for restoring_div: a transaction-level model (plain / and %)
// predicts every output each cycle; directed cases pin the model to literals.
module tb_restoring_div;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    restoring_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic: what a division must produce.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    // Transaction-level model: edges remaining until DONE, plus held results.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    bit           m_dz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            if (divisor == '0) begin
                m_done = 1'b1; m_q = '1; m_r = dividend; m_dz = 1'b1;
            end else begin
                p_q = dividend / divisor;
                p_r = dividend % divisor;
                m_left = W;
            end
        end
    end

    // Every cycle: busy, done, div_zero, quotient, remainder against the model.
    always @(negedge clk) begin
        check("cycle_outputs",
              32'({busy, done, div_zero, quotient, remainder}),
              32'({m_left > 0, m_done, m_dz, m_q, m_r}));
    end

    // Launch one division, scramble operands after acceptance, wait for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        q = quotient; r = remainder; dz = div_zero;
    endtask

    task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        logic [W-1:0] q, r;
        logic         dz;
        int           lat;
        run_op(a, b, q, r, dz, lat);
        check({name, "_latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
        check({name, "_result"}, 32'({dz, q, r}), 32'({edz, eq, er}));
    endtask

    initial begin
        logic [2*W:0] exp;
        int           pulses;

        #1 rst = 1'b1;
        #3;
        check("reset_state", 32'({busy, done, div_zero, quotient, remainder}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hand-computed cases.
        do_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        do_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        do_div("d5_7", 4'd5, 4'd7, 4'd0, 4'd5, 1'b0);
        do_div("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        do_div("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1);

        // start held with new operands through ITER and DONE.
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        dividend = 4'd6; divisor = 4'd2;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("busy_start_result", 32'({div_zero, quotient, remainder}), 32'({1'b0, 4'd4, 4'd1}));
            end
        end
        start = 1'b0;
        @(negedge clk);
        if (done) pulses++;
        check("busy_start_pulses", 32'(pulses), 32'd1);
        do_div("d6_2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0);

        // Asynchronous reset in the second ITER cycle.
        @(negedge clk);
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_iter_reset", 32'({busy, done, div_zero, quotient, remainder}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_reset", 32'(pulses), 32'd0);
        do_div("d14_4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

        // Exhaustive sweep with random idle gaps.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) @(negedge clk);
                exp = ref_div(W'(a), W'(b));
                do_div("sweep", W'(a), W'(b), exp[2*W-1:W], exp[W-1:0], exp[2*W]);
            end
        end

        // Free-running random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
